// File: rtl/line_taps_serializer.sv
// line_taps_serializer
// Parallel-to-serial companion of the tapped line shift register. Each input
// beat carries one column of LANES rows (lane k = tap at delay (k+1)*LINE_LEN-1).
// A full LINE_LEN-column block is buffered in one of two ping-pong banks and
// replayed as a byte stream in raster order, oldest row (lane LANES-1) first.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   in_valid/ready  column beat handshake; in_lanes lane k at [WIDTH*k +: WIDTH]
//   out_valid/ready sample handshake; out_data sample, out_last end of block
//   banks_full      per-bank full flags (status)
module line_taps_serializer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LINE_LEN = 16,
    parameter int unsigned LANES    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*LANES-1:0] in_lanes,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    output logic [1:0]             banks_full
);

    localparam int unsigned COL_W  = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(LINE_LEN - 1);
    localparam logic [LANE_W-1:0] LANE_TOP = LANE_W'(LANES - 1);

    logic [WIDTH-1:0] mem_q [2][LANES][LINE_LEN];
    logic [WIDTH-1:0] mem_d [2][LANES][LINE_LEN];

    logic [1:0]        full_q,    full_d;
    logic              wr_bank_q, wr_bank_d;
    logic [COL_W-1:0]  wr_col_q,  wr_col_d;
    logic              rd_bank_q, rd_bank_d;
    logic [LANE_W-1:0] rd_lane_q, rd_lane_d;
    logic [COL_W-1:0]  rd_col_q,  rd_col_d;

    logic accept;
    logic xfer;

    // Handshake outputs are pure functions of registered state.
    always_comb begin
        in_ready   = ~full_q[wr_bank_q];
        out_valid  = full_q[rd_bank_q];
        out_data   = out_valid ? mem_q[rd_bank_q][rd_lane_q][rd_col_q] : '0;
        out_last   = out_valid && (rd_lane_q == '0) && (rd_col_q == COL_LAST);
        banks_full = full_q;
        accept     = in_valid && in_ready;
        xfer       = out_valid && out_ready;
    end

    // Column write: every lane of the beat lands at wr_col of the write bank.
    always_comb begin
        mem_d = mem_q;
        if (accept) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                mem_d[wr_bank_q][k][wr_col_q] = in_lanes[WIDTH*k +: WIDTH];
            end
        end
    end

    // Pointer and full-flag next state; a completing write and a freeing read
    // always touch different banks, so both updates can apply together.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_col_d  = wr_col_q;
        rd_bank_d = rd_bank_q;
        rd_lane_d = rd_lane_q;
        rd_col_d  = rd_col_q;

        if (accept) begin
            if (wr_col_q == COL_LAST) begin
                wr_col_d          = '0;
                wr_bank_d         = ~wr_bank_q;
                full_d[wr_bank_q] = 1'b1;
            end else begin
                wr_col_d = wr_col_q + COL_W'(1);
            end
        end

        if (xfer) begin
            if (rd_col_q == COL_LAST) begin
                rd_col_d = '0;
                if (rd_lane_q == '0) begin
                    rd_lane_d         = LANE_TOP;
                    rd_bank_d         = ~rd_bank_q;
                    full_d[rd_bank_q] = 1'b0;
                end else begin
                    rd_lane_d = rd_lane_q - LANE_W'(1);
                end
            end else begin
                rd_col_d = rd_col_q + COL_W'(1);
            end
        end
    end

    // Control state; reset discards any partial or unread block.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            wr_col_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_lane_q <= LANE_TOP;
            rd_col_q  <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_col_q  <= wr_col_d;
            rd_bank_q <= rd_bank_d;
            rd_lane_q <= rd_lane_d;
            rd_col_q  <= rd_col_d;
        end
    end

    // Sample storage; contents are only observed behind the full flags.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_line_taps_serializer.sv
module tb_line_taps_serializer;

    localparam int LANES    = 4;
    localparam int LINE_LEN = 16;
    localparam int BLK      = LANES * LINE_LEN;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_lanes = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic [1:0]  banks_full;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [15:0] b_in_lanes = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [7:0]  b_out_data;
    logic        b_out_last;
    logic [1:0]  b_banks_full;

    always #5 clk = ~clk;

    line_taps_serializer #(.WIDTH(8), .LINE_LEN(16), .LANES(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_lanes(in_lanes),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .banks_full(banks_full)
    );

    line_taps_serializer #(.WIDTH(8), .LINE_LEN(4), .LANES(2)) dut_small (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_lanes(b_in_lanes),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .banks_full(b_banks_full)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: completed blocks expanded to {last, data} in raster order.
    logic [8:0] exp_q[$];
    logic [7:0] pbuf [LANES][LINE_LEN];
    int wr_cnt     = 0;
    int src_col    = 0;
    int src_blk    = 0;
    int beats_left = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] beat_word(input int c, input int tag);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < LANES; k++) w[8*k +: 8] = {2'(k), 4'(c), 2'(tag)};
        return w;
    endfunction

    // One clock: check outputs mid-cycle, then record the handshakes that fire at the edge.
    task automatic cycle();
        int nfull;
        @(negedge clk);
        if (!reset) begin
            nfull = (exp_q.size() + BLK - 1) / BLK;
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("in_ready", 32'(in_ready), 32'(nfull < 2));
            check("banks_full_cnt", 32'($countones(banks_full)), 32'(nfull));
            if (exp_q.size() != 0) begin
                check("out_data", 32'(out_data), 32'(exp_q[0][7:0]));
                check("out_last", 32'(out_last), 32'(exp_q[0][8]));
            end else begin
                check("idle_data", 32'(out_data), 32'(0));
                check("idle_last", 32'(out_last), 32'(0));
            end
            if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) begin
                for (int k = 0; k < LANES; k++) pbuf[k][wr_cnt] = in_lanes[8*k +: 8];
                wr_cnt++;
                if (wr_cnt == LINE_LEN) begin
                    for (int k = LANES - 1; k >= 0; k--)
                        for (int c = 0; c < LINE_LEN; c++)
                            exp_q.push_back({1'(k == 0 && c == LINE_LEN - 1), pbuf[k][c]});
                    wr_cnt = 0;
                end
                src_col++;
                beats_left--;
                if (src_col == LINE_LEN) begin
                    src_col = 0;
                    src_blk++;
                end
            end
        end else begin
            exp_q.delete();
            wr_cnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // mode: 0 = out_ready low, 1 = out_ready high, 2 = pseudo-random out_ready
    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            in_valid = (beats_left > 0);
            in_lanes = beat_word(src_col, src_blk);
            case (mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            cycle();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        src_col = 0;
        src_blk = 0;
        beats_left = 0;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_banks_full", 32'(banks_full), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_last", 32'(out_last), 32'(0));
    endtask

    logic [7:0] sexp [8];
    int sent;
    int got;

    initial begin
        sexp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h50, 8'h51, 8'h52, 8'h53};

        // Single block, free-running drain.
        do_reset();
        beats_left = 16;
        run(16, 1);
        check("t1_first_valid", 32'(out_valid), 32'(1));
        check("t1_first_data", 32'(out_data), 32'h0C0);
        check("t1_banks", 32'(banks_full), 32'b01);
        run(63, 1);
        check("t1_last_data", 32'(out_data), 32'h03C);
        check("t1_last_flag", 32'(out_last), 32'(1));
        run(1, 1);
        check("t1_drained", 32'(banks_full), 32'(0));
        check("t1_idle", 32'(out_valid), 32'(0));

        // Five back-to-back blocks with continuous traffic.
        beats_left = 80;
        src_blk = 1;
        run(5 * BLK + 40, 1);
        check("t2_drained", 32'(banks_full), 32'(0));
        check("t2_all_sent", 32'(beats_left), 32'(0));

        // Random downstream stalls.
        beats_left = 16;
        run(16, 1);
        run(300, 2);
        run(80, 1);
        check("t3_drained", 32'(banks_full), 32'(0));

        // Both banks full, extra beats held off, then release.
        beats_left = 40;
        run(45, 0);
        check("t4_both_full", 32'(banks_full), 32'b11);
        check("t4_in_ready", 32'(in_ready), 32'(0));
        check("t4_out_valid", 32'(out_valid), 32'(1));
        run(64, 1);
        check("t4_ready_back", 32'(in_ready), 32'(1));
        run(200, 1);
        check("t4_partial_hidden", 32'(out_valid), 32'(0));
        check("t4_banks", 32'(banks_full), 32'(0));

        // Reset mid-write and mid-read, then a fresh block.
        do_reset();
        beats_left = 7;
        run(7, 1);
        do_reset();
        beats_left = 16;
        run(16 + 20, 1);
        check("t5_mid_read", 32'(out_valid), 32'(1));
        do_reset();
        beats_left = 16;
        run(16, 1);
        check("t5_fresh_first", 32'(out_data), 32'h0C0);
        run(70, 1);
        check("t5_drained", 32'(banks_full), 32'(0));

        // Small instance: LINE_LEN=4, LANES=2.
        sent = 0;
        got = 0;
        b_out_ready = 1'b1;
        for (int i = 0; i < 40 && got < 8; i++) begin
            b_in_valid = (sent < 4);
            b_in_lanes = {8'(8'hA0 + sent), 8'(8'h50 + sent)};
            @(negedge clk);
            if (b_out_valid && b_out_ready) begin
                check("small_data", 32'(b_out_data), 32'(sexp[got]));
                check("small_last", 32'(b_out_last), 32'(got == 7));
                got++;
            end
            if (b_in_valid && b_in_ready) sent++;
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
        check("small_count", 32'(got), 32'(8));
        @(posedge clk);
        #1;
        check("small_banks", 32'(b_banks_full), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
